// File: rtl/voq_scheduler_if.sv
// Scheduler <-> datapath handshake bundle.
//   voq_req     : request matrix, bit i*PORTS+j = ingress i has a packet for egress j
//   match_ack   : datapath has consumed the current match
//   match       : crossbar configuration, same bit mapping as voq_req
//   match_valid : match is valid and held stable until acked
// master = datapath/requester side, slave = scheduler side.
interface voq_scheduler_if #(
  parameter int unsigned PORTS = 4
);
  logic [PORTS*PORTS-1:0] voq_req;
  logic                   match_ack;
  logic [PORTS*PORTS-1:0] match;
  logic                   match_valid;

  modport master (
    output voq_req,
    output match_ack,
    input  match,
    input  match_valid
  );

  modport slave (
    input  voq_req,
    input  match_ack,
    output match,
    output match_valid
  );
endinterface

// File: rtl/voq_scheduler.sv
// Single-iteration iSLIP crossbar scheduler for a virtual-output-queued switch.
// Ports:
//   clk      : clock
//   reset    : synchronous, active-high reset
//   enable   : run enable, only looked at while idle
//   bus      : voq_scheduler_if slave (voq_req/match_ack in, match/match_valid out)
//   busy     : high whenever the FSM is not idle
//   slot_cnt : count of acked time slots (wraps)
// One slot: IDLE (sample) -> GRANT -> ACCEPT -> ISSUE (hold until ack) -> IDLE.
module voq_scheduler #(
  parameter int unsigned PORTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  voq_scheduler_if.slave       bus,
  output logic                 busy,
  output logic [31:0]          slot_cnt
);

  localparam int unsigned PW = $clog2(PORTS);

  typedef enum logic [1:0] {StIdle, StGrant, StAccept, StIssue} state_e;

  state_e state_q;

  // [i][j] packing equals the flat bit i*PORTS+j of the bus vectors.
  logic [PORTS-1:0][PORTS-1:0] req_q;
  logic [PORTS-1:0][PORTS-1:0] match_q;
  // grant_q[j][i]: egress j granted ingress i (one-hot per egress).
  logic [PORTS-1:0][PORTS-1:0] grant_q;
  logic [PORTS-1:0][PORTS-1:0] grant_d;
  logic [PORTS-1:0][PORTS-1:0] accept_d;
  logic [PORTS-1:0][PW-1:0]    grant_ptr_q;
  logic [PORTS-1:0][PW-1:0]    accept_ptr_q;
  logic                        match_valid_q;
  logic [PW-1:0]               g_idx;
  logic [PW-1:0]               a_idx;

  assign bus.match       = match_q;
  assign bus.match_valid = match_valid_q;

  // Grant: each egress picks the first requesting ingress at or after its pointer.
  // Scanning the offsets from high to low lets the lowest offset win.
  always_comb begin
    grant_d = '0;
    g_idx   = '0;
    for (int j = 0; j < PORTS; j++) begin
      for (int k = PORTS - 1; k >= 0; k--) begin
        g_idx = grant_ptr_q[j] + PW'(k);
        if (req_q[g_idx][j]) begin
          grant_d[j]        = '0;
          grant_d[j][g_idx] = 1'b1;
        end
      end
    end
  end

  // Accept: each ingress picks the first granting egress at or after its pointer.
  always_comb begin
    accept_d = '0;
    a_idx    = '0;
    for (int i = 0; i < PORTS; i++) begin
      for (int k = PORTS - 1; k >= 0; k--) begin
        a_idx = accept_ptr_q[i] + PW'(k);
        if (grant_q[a_idx][i]) begin
          accept_d[i]        = '0;
          accept_d[i][a_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      req_q         <= '0;
      grant_q       <= '0;
      match_q       <= '0;
      match_valid_q <= 1'b0;
      busy          <= 1'b0;
      slot_cnt      <= '0;
      grant_ptr_q   <= '0;
      accept_ptr_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable && (|bus.voq_req)) begin
            req_q   <= bus.voq_req;
            busy    <= 1'b1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          grant_q <= grant_d;
          state_q <= StAccept;
        end
        StAccept: begin
          match_q       <= accept_d;
          match_valid_q <= 1'b1;
          state_q       <= StIssue;
        end
        StIssue: begin
          if (bus.match_ack) begin
            // Only matched ports advance; a match is a permutation subset, so
            // each pointer is written at most once here.
            for (int i = 0; i < PORTS; i++) begin
              for (int j = 0; j < PORTS; j++) begin
                if (match_q[i][j]) begin
                  grant_ptr_q[j]  <= PW'(i + 1);
                  accept_ptr_q[i] <= PW'(j + 1);
                end
              end
            end
            slot_cnt      <= slot_cnt + 32'd1;
            match_q       <= '0;
            match_valid_q <= 1'b0;
            busy          <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_voq_scheduler.sv
// Directed bench for voq_scheduler at PORTS=4 with hand-computed iSLIP matches.
module tb_voq_scheduler;

  localparam int unsigned PORTS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        busy;
  logic [31:0] slot_cnt;

  voq_scheduler_if #(.PORTS(PORTS)) bus ();

  voq_scheduler #(.PORTS(PORTS)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy),
    .slot_cnt (slot_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    enable        = 1'b0;
    bus.voq_req   = '0;
    bus.match_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.match_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, bus.match_valid}, 32'd1);
  endtask

  task automatic run_slot(input string tag, input logic [15:0] req, input logic [15:0] exp,
                          input logic [31:0] exp_cnt);
    enable      = 1'b1;
    bus.voq_req = req;
    wait_valid(tag);
    enable = 1'b0;
    check({tag, "_match"}, {16'd0, bus.match}, {16'd0, exp});
    bus.match_ack = 1'b1;
    tick();
    bus.match_ack = 1'b0;
    check({tag, "_cnt"}, slot_cnt, exp_cnt);
  endtask

  function automatic bit legal(input logic [15:0] req, input logic [15:0] m);
    int unsigned r;
    int unsigned c;
    if ((m & ~req) != 16'd0) return 1'b0;
    if (m == 16'd0) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = 0;
      c = 0;
      for (int j = 0; j < 4; j++) begin
        r += int'(m[i*4+j]);
        c += int'(m[j*4+i]);
      end
      if (r > 1 || c > 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] m0;
    logic [15:0] req;
    logic [15:0] seen;
    bit          stable;

    // Reset state
    do_reset();
    check("rst_valid", {31'd0, bus.match_valid}, 32'd0);
    check("rst_match", {16'd0, bus.match}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cnt", slot_cnt, 32'd0);

    // Single request, ack tied high: valid after the third edge, 4-cycle slot
    enable        = 1'b1;
    bus.voq_req   = 16'h0001;
    bus.match_ack = 1'b1;
    tick();
    check("lat_busy", {31'd0, busy}, 32'd1);
    check("lat_v1", {31'd0, bus.match_valid}, 32'd0);
    tick();
    check("lat_v2", {31'd0, bus.match_valid}, 32'd0);
    tick();
    check("lat_v3", {31'd0, bus.match_valid}, 32'd1);
    check("lat_match", {16'd0, bus.match}, 32'h0001);
    enable = 1'b0;
    tick();
    check("lat_done_v", {31'd0, bus.match_valid}, 32'd0);
    check("lat_done_cnt", slot_cnt, 32'd1);
    check("lat_done_busy", {31'd0, busy}, 32'd0);
    bus.match_ack = 1'b0;
    // grant_ptr[0]=1: egress 0 now prefers ingress 1
    run_slot("gptr0", 16'h0011, 16'h0010, 32'd2);
    // accept_ptr[0]=1: ingress 0 now prefers egress 1
    run_slot("aptr0", 16'h0003, 16'h0002, 32'd3);

    // Full request matrix: pointers desynchronise into rotating permutations
    do_reset();
    run_slot("full1", 16'hFFFF, 16'h0001, 32'd1);
    run_slot("full2", 16'hFFFF, 16'h0012, 32'd2);
    run_slot("full3", 16'hFFFF, 16'h0124, 32'd3);
    run_slot("full4", 16'hFFFF, 16'h1248, 32'd4);
    run_slot("full5", 16'hFFFF, 16'h2481, 32'd5);

    // Enable low: stays idle
    do_reset();
    bus.voq_req = 16'h8421;
    for (int n = 0; n < 5; n++) tick();
    check("en0_busy", {31'd0, busy}, 32'd0);
    check("en0_cnt", slot_cnt, 32'd0);
    // One-cycle enable pulse still completes the slot
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check("en1_busy", {31'd0, busy}, 32'd1);
    wait_valid("en1");
    m0 = bus.match;
    check("en1_match", {16'd0, m0}, 32'h8421);
    // Ack withheld, request toggled: outputs frozen
    stable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      bus.voq_req = 16'($urandom);
      tick();
      if (bus.match !== m0 || bus.match_valid !== 1'b1 || slot_cnt !== 32'd0) stable = 1'b0;
    end
    check("hold_stable", {31'd0, stable}, 32'd1);
    bus.match_ack = 1'b1;
    tick();
    check("hold_ack_v", {31'd0, bus.match_valid}, 32'd0);
    check("hold_ack_busy", {31'd0, busy}, 32'd0);
    check("hold_ack_cnt", slot_cnt, 32'd1);
    // Ack outside ISSUE is ignored
    for (int n = 0; n < 3; n++) tick();
    bus.match_ack = 1'b0;
    check("idle_ack_cnt", slot_cnt, 32'd1);
    // Pointers advanced exactly once by the 8421 slot
    run_slot("post_hold", 16'hFFFF, 16'h4218, 32'd2);

    // Reset mid-ISSUE after 3 slots discards the slot and the pointer history
    do_reset();
    run_slot("pre1", 16'hFFFF, 16'h0001, 32'd1);
    run_slot("pre2", 16'hFFFF, 16'h0012, 32'd2);
    run_slot("pre3", 16'hFFFF, 16'h0124, 32'd3);
    enable      = 1'b1;
    bus.voq_req = 16'hFFFF;
    wait_valid("pre4");
    enable = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_v", {31'd0, bus.match_valid}, 32'd0);
    check("mid_rst_match", {16'd0, bus.match}, 32'd0);
    check("mid_rst_cnt", slot_cnt, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    run_slot("post_rst", 16'hFFFF, 16'h0001, 32'd1);

    // Persistent full request: every pair served within PORTS*PORTS slots
    do_reset();
    seen = '0;
    for (int s = 0; s < 16; s++) begin
      enable      = 1'b1;
      bus.voq_req = 16'hFFFF;
      wait_valid("fair");
      enable = 1'b0;
      seen |= bus.match;
      bus.match_ack = 1'b1;
      tick();
      bus.match_ack = 1'b0;
    end
    check("fair_cover", {16'd0, seen}, 32'h0000FFFF);

    // Random requests: structural legality of every match
    for (int s = 0; s < 300; s++) begin
      req         = 16'($urandom_range(1, 16'hFFFF));
      enable      = 1'b1;
      bus.voq_req = req;
      wait_valid("rnd");
      enable = 1'b0;
      check("rnd_legal", {31'd0, legal(req, bus.match)}, 32'd1);
      bus.match_ack = 1'b1;
      tick();
      bus.match_ack = 1'b0;
    end
    check("rnd_cnt", slot_cnt, 32'd316);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/voq_scheduler.md
VOQ_SCHEDULER -- requirements
Module: voq_scheduler

Interface
REQ-001 Parameter: PORTS, default 4, number of ingress and egress ports; SHALL be a power of two in the range 2..8.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  scheduler run enable (driven from ctrl bit 0).
REQ-005 voq_req  input  PORTS*PORTS  request matrix; bit i*PORTS+j = ingress i holds a packet for egress j.
REQ-006 match_ack  input  1  datapath has consumed the current match.
REQ-007 match  output  PORTS*PORTS  crossbar configuration; same bit mapping as voq_req.
REQ-008 match_valid  output  1  match is valid and held stable.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 slot_cnt  output  32  number of completed (acked) time slots.

Function
REQ-011 FSM states SHALL be IDLE, GRANT, ACCEPT and ISSUE; the state register SHALL be the only control state.
REQ-012 IDLE: if enable=1 and voq_req is non-zero, register voq_req into req_q and go to GRANT; otherwise stay in IDLE.
REQ-013 GRANT (1 cycle): for each egress j, grant_q[j] = first ingress i with req_q[i*PORTS+j]=1, searching round-robin from grant_ptr[j] upward modulo PORTS; grant none if no such i; then go to ACCEPT.
REQ-014 ACCEPT (1 cycle): for each ingress i, accept the first egress j that granted i, searching from accept_ptr[i] upward modulo PORTS; register the result into match; then go to ISSUE.
REQ-015 Matching SHALL be single-iteration iSLIP; match SHALL have at most one bit set per ingress row and per egress column, and SHALL be a subset of req_q.
REQ-016 ISSUE: assert match_valid; hold match and match_valid stable until the cycle in which match_ack=1.
REQ-017 On the ack cycle, for every accepted pair (i,j):
  - grant_ptr[j] <= (i+1) mod PORTS;
  - accept_ptr[i] <= (j+1) mod PORTS.
REQ-018 On the ack cycle, pointers of unmatched ports SHALL be unchanged.
REQ-019 On the ack cycle: slot_cnt <= slot_cnt+1, wrapping from 0xFFFFFFFF to 0; match_valid <= 0; match <= 0; go to IDLE.
REQ-020 match_ack outside ISSUE SHALL be ignored.
REQ-021 voq_req changes after sampling in IDLE SHALL NOT affect the in-flight slot.
REQ-022 enable SHALL be sampled only in IDLE; deasserting enable mid-slot SHALL let the slot complete.
REQ-023 Latency: req sampled at IDLE edge N, match_valid=1 from edge N+3; minimum slot period is 4 cycles (ack at the first ISSUE cycle).
REQ-024 The ack cycle returns to IDLE; a new sample SHALL NOT occur in the same cycle as the ack.
REQ-025 Pointer arithmetic SHALL use log2(PORTS)-bit fields that wrap naturally.

Reset
REQ-026 reset=1 SHALL, on the next edge and from any state, force:
  - state=IDLE, match=0, match_valid=0, busy=0, slot_cnt=0;
  - all grant_ptr and accept_ptr = 0;
  - req_q and grant_q = 0.
REQ-027 Reset asserted mid-slot SHALL discard the slot without incrementing slot_cnt or updating pointers.

Verification (PORTS=4)
REQ-028 After reset, enable=1, voq_req=16'h0001, match_ack tied high -> match_valid=1 with match=16'h0001 three cycles after sampling; then slot_cnt=1, grant_ptr[0]=1, accept_ptr[0]=1.
REQ-029 From reset, voq_req=16'hFFFF, ack every slot:
  - slot 1 match=16'h0001;
  - slot 2 match=16'h0012 (ingress0->egress1, ingress1->egress0).
REQ-030 match_ack held low for 10 cycles in ISSUE, with voq_req toggled meanwhile -> match and match_valid constant, pointers unchanged, slot_cnt unchanged; ack -> IDLE in 1 cycle.
REQ-031 enable handling:
  - enable=0, voq_req=16'h8421 -> stays IDLE, busy=0;
  - enable=1 for one IDLE cycle then 0 -> slot completes with match=16'h8421.
REQ-032 Reset pulse during ISSUE after 3 completed slots -> next cycle match_valid=0, match=0, slot_cnt=0; following slot with voq_req=16'hFFFF gives match=16'h0001.
REQ-033 Random voq_req over 10k slots -> every match is a subset of the sampled request with at most one bit per row and column; each persistently requesting pair is served within PORTS*PORTS slots.
